// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with valid/ready handshakes and a full 2*DATA_WIDTH product.
// Optional early termination when the remaining multiplier bits are zero: define SEQ_MUL_EARLY_TERM_EN.
module seq_multiplier #(
  parameter int DATA_WIDTH = 8,
  parameter int SIGNED     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      busy
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [W-1:0]  ONE_W    = W'(1);
  localparam logic [W2-1:0] ONE_W2   = W2'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W2-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W2-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic [W2-1:0]  product_q, product_d;

  logic [W-1:0]   mag_a, mag_b;
  logic           last_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    last_step = 1'b0;

    // The most negative operand negates to itself, which read as unsigned is already its magnitude.
    mag_a = a;
    mag_b = b;
    if (SIGNED != 0) begin
      if (a[W-1]) mag_a = ~a + ONE_W;
      if (b[W-1]) mag_b = ~b + ONE_W;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = (SIGNED != 0) ? (a[W-1] ^ b[W-1]) : 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + ONE_C;
        last_step = (cnt_q == LAST_CNT);
`ifdef SEQ_MUL_EARLY_TERM_EN
        last_step = last_step || (mplier_d == '0);
`endif
        if (last_step) begin
          state_d   = S_DONE;
          product_d = neg_q ? (~acc_d + ONE_W2) : acc_d;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: one unsigned and one signed 8-bit instance, fixed vectors,
// hand-written handshake/reset sequences and randomized operations against an arithmetic model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv_u = 1'b0, ir_u, ov_u, or_u = 1'b0, busy_u;
  logic [7:0]  a_u = '0, b_u = '0;
  logic [15:0] prod_u;

  logic        iv_s = 1'b0, ir_s, ov_s, or_s = 1'b0, busy_s;
  logic [7:0]  a_s = '0, b_s = '0;
  logic [15:0] prod_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.DATA_WIDTH(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(iv_u), .in_ready(ir_u), .a(a_u), .b(b_u),
    .out_valid(ov_u), .out_ready(or_u), .product(prod_u), .busy(busy_u)
  );

  seq_multiplier #(.DATA_WIDTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(iv_s), .in_ready(ir_s), .a(a_s), .b(b_s),
    .out_valid(ov_s), .out_ready(or_s), .product(prod_s), .busy(busy_s)
  );

  typedef struct {
    bit          sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat_fix;
    int          lat_et;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_prod(input bit s, input logic [7:0] x, input logic [7:0] y);
    int xi, yi;
    if (s) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    return 16'(xi * yi);
  endfunction

  function automatic int ref_lat(input bit s, input logic [7:0] y);
    int m, n;
    m = (s && y[7]) ? 256 - int'(y) : int'(y);
    n = 1;
    for (int k = 0; k < 8; k++) if (m[k]) n = k + 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
    return n;
`else
    return (n > 0) ? 8 : 8;
`endif
  endfunction

  function automatic logic f_ov(input bit s);
    return s ? ov_s : ov_u;
  endfunction
  function automatic logic f_ir(input bit s);
    return s ? ir_s : ir_u;
  endfunction
  function automatic logic f_busy(input bit s);
    return s ? busy_s : busy_u;
  endfunction
  function automatic logic [15:0] f_prod(input bit s);
    return s ? prod_s : prod_u;
  endfunction

  task automatic drive(input bit s, input logic v, input logic [7:0] av, input logic [7:0] bv);
    if (s) begin iv_s = v; a_s = av; b_s = bv; end
    else   begin iv_u = v; a_u = av; b_u = bv; end
  endtask

  task automatic set_or(input bit s, input logic v);
    if (s) or_s = v; else or_u = v;
  endtask

  // Called at #1 after an edge with the selected instance idle.
  task automatic do_op(input bit s, input logic [7:0] av, input logic [7:0] bv,
                       input int hold, input bit pulse,
                       output logic [15:0] p, output int lat);
    chk("idle_ready", 32'(f_ir(s)), 32'd1);
    drive(s, 1'b1, av, bv);
    set_or(s, 1'($urandom % 2));
    @(posedge clk); #1;
    drive(s, 1'b0, 8'($urandom), 8'($urandom));
    chk("busy_run", 32'(f_busy(s)), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (f_ov(s)) break;
      set_or(s, 1'($urandom % 2));
    end
    if (!f_ov(s)) chk("done_timeout", 32'(f_ov(s)), 32'd1);
    p = f_prod(s);
    set_or(s, 1'b0);
    for (int h = 0; h < hold; h++) begin
      if (pulse) drive(s, 1'((h % 2) == 0), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      chk("bp_valid", 32'(f_ov(s)), 32'd1);
      chk("bp_stable", 32'(f_prod(s)), 32'(p));
      chk("bp_no_ready", 32'(f_ir(s)), 32'd0);
    end
    drive(s, 1'b0, 8'($urandom), 8'($urandom));
    set_or(s, 1'b1);
    @(posedge clk); #1;
    set_or(s, 1'b0);
    chk("ov_drop", 32'(f_ov(s)), 32'd0);
    chk("ready_back", 32'(f_ir(s)), 32'd1);
    chk("prod_hold", 32'(f_prod(s)), 32'(p));
  endtask

  vec_t        vt[12];
  logic [15:0] p;
  int          lat;
  int          exp_lat;
  bit          seen_ov;
  logic [15:0] got_q[$];
  int          acc_cyc[$];
  bit          acc_now;

  initial begin
    vt[0]  = '{0, 8'hFF, 8'hFF, 16'hFE01, 8, 8};
    vt[1]  = '{0, 8'd12, 8'd10, 16'd120,  8, 4};
    vt[2]  = '{1, 8'h80, 8'h80, 16'h4000, 8, 8};
    vt[3]  = '{1, 8'hFD, 8'h05, 16'hFFF1, 8, 3};
    vt[4]  = '{1, 8'h7F, 8'h80, 16'hC080, 8, 8};
    vt[5]  = '{0, 8'hFF, 8'h00, 16'h0000, 8, 1};
    vt[6]  = '{0, 8'h03, 8'h10, 16'h0030, 8, 5};
    vt[7]  = '{1, 8'hFF, 8'h00, 16'h0000, 8, 1};
    vt[8]  = '{0, 8'h07, 8'h09, 16'd63,   8, 4};
    vt[9]  = '{0, 8'd100, 8'd3, 16'd300,  8, 2};
    vt[10] = '{1, 8'h05, 8'hFF, 16'hFFFB, 8, 1};
    vt[11] = '{0, 8'h80, 8'h01, 16'h0080, 8, 1};

    #12;
    chk("rst_ready_u", 32'(ir_u), 32'd1);
    chk("rst_valid_u", 32'(ov_u), 32'd0);
    chk("rst_busy_u",  32'(busy_u), 32'd0);
    chk("rst_prod_u",  32'(prod_u), 32'd0);
    chk("rst_prod_s",  32'(prod_s), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
`ifdef SEQ_MUL_EARLY_TERM_EN
      exp_lat = vt[i].lat_et;
`else
      exp_lat = vt[i].lat_fix;
`endif
      do_op(vt[i].sgn, vt[i].a, vt[i].b, 0, 1'b0, p, lat);
      chk($sformatf("vec%0d_prod", i), 32'(p), 32'(vt[i].p));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat));
    end

    // Backpressure with ignored in_valid pulses while DONE.
    do_op(1'b0, 8'd12, 8'd10, 5, 1'b1, p, lat);
    chk("bp_prod", 32'(p), 32'd120);
    @(posedge clk); #1;
    chk("bp_no_stray_accept", 32'(busy_u), 32'd0);

    // Asynchronous reset in the 4th RUN cycle.
    drive(1'b0, 1'b1, 8'd200, 8'd200);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 32'(busy_u), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ir_u), 32'd1);
    chk("arst_valid", 32'(ov_u), 32'd0);
    chk("arst_busy",  32'(busy_u), 32'd0);
    chk("arst_prod",  32'(prod_u), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_ov = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov_u) seen_ov = 1'b1;
    end
    chk("arst_no_stale_valid", 32'(seen_ov), 32'd0);
    do_op(1'b0, 8'd2, 8'd3, 0, 1'b0, p, lat);
    chk("arst_next_prod", 32'(p), 32'd6);

    // Back-to-back with in_valid held high and out_ready held high.
    drive(1'b0, 1'b1, 8'd7, 8'd9);
    set_or(1'b0, 1'b1);
    got_q.delete();
    acc_cyc.delete();
    for (int cyc = 0; cyc < 80 && got_q.size() < 2; cyc++) begin
      acc_now = ir_u && iv_u;
      @(posedge clk); #1;
      if (acc_now) begin
        acc_cyc.push_back(cyc);
        if (acc_cyc.size() == 1) drive(1'b0, 1'b1, 8'd100, 8'd3);
        else drive(1'b0, 1'b0, 8'd0, 8'd0);
      end
      if (ov_u) begin
        got_q.push_back(prod_u);
        chk("b2b_no_accept_in_done", 32'(ir_u), 32'd0);
      end
    end
    chk("b2b_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("b2b_first", 32'(got_q[0]), 32'd63);
      chk("b2b_second", 32'(got_q[1]), 32'd300);
    end
    chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2)
      chk("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'(ref_lat(1'b0, 8'd9) + 2));
    @(posedge clk); #1;
    set_or(1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    chk("b2b_idle", 32'(ir_u), 32'd1);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      bit         s;
      logic [7:0] ra, rb;
      s  = 1'($urandom % 2);
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom % 6)
        0: rb = 8'h00;
        1: rb = 8'h80;
        2: rb = 8'(1 << ($urandom % 8));
        default: ;
      endcase
      do_op(s, ra, rb, int'($urandom % 3), 1'($urandom % 2), p, lat);
      chk("rnd_prod", 32'(p), 32'(ref_prod(s, ra, rb)));
      chk("rnd_lat", 32'(lat), 32'(ref_lat(s, rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
